// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - synchronous circular-buffer FIFO with threshold and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle-latency reads.
module fifo_buffer #(
  parameter int DATA_WIDTH      = 12,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int                 DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A pop frees a slot in the same cycle, so a push into a full buffer is accepted alongside it.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow_err  <= 1'b1;
      if (pop && empty)     underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (reset)       data_out <= '0;
    else if (pop_ok) data_out <= mem[rd_ptr];
  end
`endif

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed and randomized checks of fifo_buffer against a queue-based model.
module tb_fifo_buffer;

  localparam int DW    = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          empty, full, almost_empty, almost_full, overflow_err, underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the registered read word and sticky errors.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            started = 1'b0;

  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      started = 1'b1;
    end else begin
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      if (pop && q.size() == 0) m_unf = 1'b1;
      if (push && !push_ok) m_ovf = 1'b1;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(data_in);
    end
  end

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE_TH));
      check("almost_full", 32'(almost_full), 32'(q.size() >= AF_TH));
      check("data_out", 32'(data_out), 32'(exp_dout()));
      check("overflow_err", 32'(overflow_err), 32'(m_ovf));
      check("underflow_err", 32'(underflow_err), 32'(m_unf));
    end
  end

  task automatic cyc(input bit r, input bit p, input bit pp, input logic [DW-1:0] d);
    reset = r; push = p; pop = pp; data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] words [8];

  initial begin
    words[0] = 12'hABC;
    for (int i = 1; i < 8; i++) words[i] = DW'(i);

    // Reset held two cycles.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_errs", 32'({overflow_err, underflow_err}), 0);

    // Fill to depth, watching threshold flags.
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, words[k]);
      check("fill_count", 32'(count), 32'(k + 1));
      check("fill_ae", 32'(almost_empty), 32'(k + 1 <= 1));
      check("fill_af", 32'(almost_full), 32'(k + 1 >= 6));
      check("fill_full", 32'(full), 32'(k + 1 == 8));
    end
    cyc(0, 1, 0, 12'hFFF);
    check("ovf_count", 32'(count), 8);
    check("ovf_flag", 32'(overflow_err), 1);

    // Drain in eight consecutive pops.
`ifdef FIFO_FWFT_EN
    check("fwft_first", 32'(data_out), 32'h0ABC);
`endif
    for (int k = 0; k < 8; k++) begin
`ifdef FIFO_FWFT_EN
      check("drain_word", 32'(data_out), 32'(words[k]));
      cyc(0, 0, 1, 0);
`else
      cyc(0, 0, 1, 0);
      check("drain_word", 32'(data_out), 32'(words[k]));
`endif
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);

    // Simultaneous push/pop at count 3 and at full.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, DW'(12'h100 + k));
    cyc(0, 1, 1, 12'h1AA);
    check("pp3_count", 32'(count), 3);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, DW'(12'h200 + k));
    check("pp8_pre", 32'(count), 8);
    cyc(0, 1, 1, 12'h2FF);
    check("pp8_count", 32'(count), 8);
    check("pp8_ovf", 32'(overflow_err), 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0);

    // Underflow is sticky through later traffic.
    cyc(0, 0, 1, 0);
    check("unf_flag", 32'(underflow_err), 1);
    check("unf_count", 32'(count), 0);
    cyc(0, 1, 1, 12'h321);
    check("unf_pushpop_count", 32'(count), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 12'h055);
    check("unf_sticky", 32'(underflow_err), 1);

    // Reset at count 5 with push asserted.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, DW'(12'h300 + k));
    cyc(1, 1, 0, 12'h777);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_errs", 32'({overflow_err, underflow_err}), 0);
    cyc(0, 0, 1, 0);
    check("mid_rst_unf", 32'(underflow_err), 1);

    // Randomized traffic with varying push/pop bias and rare resets.
    for (int blk = 0; blk < 30; blk++) begin
      int pp = $urandom_range(10, 90);
      int qp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        cyc(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < pp),
            ($urandom_range(0, 99) < qp),
            DW'($urandom));
      end
    end
    cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 12, word width; matches the 12-bit demux data path.
REQ-002 Parameter ADDR_WIDTH, default 3, pointer width; depth = 2**ADDR_WIDTH = 8.
REQ-003 Parameter ALMOST_FULL_TH, default 6, count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_TH, default 1, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 push  input  1  write request; data_in captured at the same edge.
REQ-008 pop  input  1  read request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 data_out  output  DATA_WIDTH  read data.
REQ-011 count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
REQ-012 empty, full  output  1 each  count==0 / count==depth.
REQ-013 almost_empty, almost_full  output  1 each  threshold flags per REQ-003/004.
REQ-014 overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-015 Storage: circular buffer of depth words; wr_ptr and rd_ptr wrap modulo depth.
REQ-016 Accepted push (push=1 and (full=0 or accepted pop same cycle)): mem[wr_ptr]<=data_in, wr_ptr+1.
REQ-017 Accepted pop (pop=1 and empty=0): rd_ptr+1.
REQ-018 count: +1 on push-only accepted, -1 on pop-only accepted, unchanged when both or neither accepted.
REQ-019 All flags are decoded from the registered count; they reflect the edge that updated count, with no extra cycle.
REQ-020 Push while full with no pop: word dropped, pointers/count unchanged, overflow_err<=1.
REQ-021 Push while full with pop same cycle: both accepted, count stays depth, no overflow.
REQ-022 Pop while empty: ignored, underflow_err<=1; a simultaneous push is still accepted (count 0->1).
REQ-023 Error flags remain 1 until reset.
REQ-024 Default read mode: on accepted pop, data_out<=mem[rd_ptr] at that edge (1-cycle latency); data_out holds its value otherwise.
REQ-025 Write-to-read ordering is strict FIFO; no bypass of stored words.

Reset
REQ-026 With reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow_err=0, underflow_err=0.
REQ-027 Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Reset has priority over push/pop in the same cycle; reset mid-operation discards all stored words.
REQ-029 Memory contents need not be cleared.

Configuration
REQ-030 Macro FIFO_FWFT_EN: when defined, first-word-fall-through: data_out = mem[rd_ptr] combinationally while empty=0, 0 while empty=1; pop consumes the displayed word.
REQ-031 Without FIFO_FWFT_EN, read behaviour is REQ-024; all other requirements are identical in both builds.

Verification
REQ-032 Reset held 2 cycles -> count=0, empty=1, almost_empty=1, full=0, data_out=0, both errors 0.
REQ-033 Push 0xABC,0x001..0x007 (8 words) -> almost_empty drops at count 2, almost_full at count 6, full at count 8; 9th push 0xFFF -> dropped, overflow_err=1, count=8.
REQ-034 Pop 8 consecutive cycles from full -> default build: data_out=0xABC the cycle after first pop, then 0x001..0x007; empty=1 after 8th; FWFT build: data_out=0xABC before first pop.
REQ-035 Simultaneous push/pop at count 3 -> count stays 3, order preserved; at count 8 -> count stays 8, overflow_err stays 0.
REQ-036 Pop with empty=1 -> underflow_err=1, count=0; later push/pop traffic does not clear it.
REQ-037 Reset asserted at count 5 with push=1 -> next cycle count=0, empty=1, errors 0, pushed word not stored.
